// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative RV32M multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ABS_A  = 3'd1,
        ABS_B  = 3'd2,
        CALC   = 3'd3,
        NEG_LO = 3'd4,
        NEG_HI = 3'd5,
        DONE   = 3'd6
    } mul_state_t;

    localparam int unsigned MUL_ITERS = 32;
    localparam int unsigned CNT_W     = $clog2(MUL_ITERS);

    // Counter increment built from half-adder cells; the shared adder is busy in CALC.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        logic             c;
        c = 1'b1;
        for (int i = 0; i < int'(CNT_W); i++) begin
            r[i] = v[i] ^ c;
            c    = c & v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/CLA32bit.sv
// 32-bit adder: 4-bit carry-lookahead groups with group carries chained between them.
module CLA32bit (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);

    logic [7:0][3:0] g;
    logic [7:0][3:0] p;
    logic [7:0][3:0] c;

    assign g = i_a & i_b;
    assign p = i_a ^ i_b;

    always_comb begin : carry_net
        logic carry;
        carry = i_cin;
        c     = '0;
        for (int k = 0; k < 8; k++) begin
            c[k][0] = carry;
            c[k][1] = g[k][0] | (p[k][0] & carry);
            c[k][2] = g[k][1] | (p[k][1] & g[k][0]) | (p[k][1] & p[k][0] & carry);
            c[k][3] = g[k][2] | (p[k][2] & g[k][1]) | (p[k][2] & p[k][1] & g[k][0])
                    | (p[k][2] & p[k][1] & p[k][0] & carry);
            carry   = g[k][3] | (p[k][3] & g[k][2]) | (p[k][3] & p[k][2] & g[k][1])
                    | (p[k][3] & p[k][2] & p[k][1] & g[k][0])
                    | (p[k][3] & p[k][2] & p[k][1] & p[k][0] & carry);
        end
        o_cout = carry;
    end

    assign o_sum = p ^ c;

endmodule

// File: rtl/mul_seq32.sv
// Iterative 32x32 shift-add multiplier for MUL/MULH/MULHSU/MULHU; every addition
// goes through a single CLA32bit whose inputs are selected by the FSM state.
module mul_seq32
    import mul_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  mul_op_t     i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_result
);

    mul_state_t       state;
    mul_op_t          op_r;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi, lo, mcand;
    logic             neg_a, neg_b, neg, carry_r;

    logic [31:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout;
    logic        a_signed, b_signed;

    assign a_signed = (i_op == OP_MULH) || (i_op == OP_MULHSU);
    assign b_signed = (i_op == OP_MULH);

    CLA32bit u_cla (
        .i_a    (add_a),
        .i_b    (add_b),
        .i_cin  (add_cin),
        .o_sum  (add_sum),
        .o_cout (add_cout)
    );

    // Adder operand mux: conditional two's-complement via ~x + cin, or shift-add step.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        unique case (state)
            ABS_A: begin
                add_a   = neg_a ? ~mcand : mcand;
                add_cin = neg_a;
            end
            ABS_B: begin
                add_a   = neg_b ? ~lo : lo;
                add_cin = neg_b;
            end
            CALC: begin
                add_a = hi;
                add_b = lo[0] ? mcand : '0;
            end
            NEG_LO: begin
                add_a   = neg ? ~lo : lo;
                add_cin = neg;
            end
            NEG_HI: begin
                add_a   = neg ? ~hi : hi;
                add_cin = neg & carry_r;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            op_r     <= OP_MUL;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            mcand    <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            neg      <= 1'b0;
            carry_r  <= 1'b0;
            o_valid  <= 1'b0;
            o_ready  <= 1'b1;
            o_result <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_valid) begin
                        op_r    <= i_op;
                        mcand   <= i_a;
                        lo      <= i_b;
                        neg_a   <= a_signed & i_a[31];
                        neg_b   <= b_signed & i_b[31];
                        neg     <= (a_signed & i_a[31]) ^ (b_signed & i_b[31]);
                        o_ready <= 1'b0;
                        state   <= ABS_A;
                    end
                end
                ABS_A: begin
                    mcand <= add_sum;
                    state <= ABS_B;
                end
                ABS_B: begin
                    lo    <= add_sum;
                    hi    <= '0;
                    cnt   <= '0;
                    state <= CALC;
                end
                CALC: begin
                    {hi, lo} <= {add_cout, add_sum, lo[31:1]};
                    cnt      <= cnt_inc(cnt);
                    if (cnt == '1) begin
                        state <= NEG_LO;
                    end
                end
                NEG_LO: begin
                    lo      <= add_sum;
                    carry_r <= neg & add_cout;
                    state   <= NEG_HI;
                end
                NEG_HI: begin
                    hi       <= add_sum;
                    o_result <= (op_r == OP_MUL) ? lo : add_sum;
                    o_valid  <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq32.sv
// Randomized scoreboard bench for mul_seq32 against a 64-bit arithmetic product model.
module tb_mul_seq32;
    import mul_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    mul_op_t     i_op = OP_MUL;
    logic [31:0] i_a = '0;
    logic [31:0] i_b = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_result;

    mul_seq32 dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] res;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   seen = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Reference: sign- or zero-extend to 64 bits and multiply; low 64 bits are exact.
    function automatic logic [31:0] model(input mul_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        bit sa, sb;
        sa = (op == OP_MULH) || (op == OP_MULHSU);
        sb = (op == OP_MULH);
        ea = sa ? {{32{a[31]}}, a} : {32'h0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (op == OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    // Monitor: compare each newly presented result and its latency against the scoreboard.
    always @(negedge i_clk) begin
        if (o_valid && !seen) begin
            seen = 1'b1;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got %h with nothing outstanding", o_result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", o_result, e.res);
                check("latency", 32'(cyc - e.acc), 32'd36);
            end
        end
        if (!o_valid) seen = 1'b0;
    end

    task automatic issue(input mul_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] req);
        int w;
        exp_t e;
        w = 0;
        while (!o_ready && w < 200) begin
            @(negedge i_clk);
            w++;
        end
        if (!o_ready) begin
            timeout("accept_wait");
        end else begin
            i_valid = 1'b1;
            i_op    = op;
            i_a     = a;
            i_b     = b;
            @(negedge i_clk);
            e.res = req;
            e.acc = cyc;
            sb_q.push_back(e);
            i_valid = 1'b0;
            i_a     = $urandom;
            i_b     = $urandom;
            i_op    = mul_op_t'(2'($urandom_range(0, 3)));
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((sb_q.size() != 0 || !o_ready) && w < 200) begin
            @(negedge i_clk);
            w++;
        end
        if (sb_q.size() != 0 || !o_ready) timeout("idle_wait");
    endtask

    logic [31:0] corner[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0001};

    initial begin
        mul_op_t     op;
        logic [31:0] a, b, req;
        int          w;

        repeat (2) @(negedge i_clk);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_result", o_result, 32'h0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Directed corner cases with hand-derived results.
        issue(OP_MUL,    32'd7,         32'd6,         32'h0000_002A); wait_idle();
        issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE); wait_idle();
        issue(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001); wait_idle();
        issue(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000); wait_idle();
        issue(OP_MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000); wait_idle();
        issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
        issue(OP_MULH,   32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF); wait_idle();
        issue(OP_MUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1); wait_idle();

        // Back-pressure with ignored busy-time requests.
        a = $urandom;
        b = $urandom;
        req = model(OP_MULH, a, b);
        i_ready = 1'b0;
        issue(OP_MULH, a, b, req);
        for (int i = 0; i < 20; i++) begin
            i_valid = 1'($urandom_range(0, 1));
            i_a = $urandom;
            i_b = $urandom;
            @(negedge i_clk);
            check("busy_ready", 32'(o_ready), 32'd0);
        end
        i_valid = 1'b0;
        w = 0;
        while (!o_valid && w < 100) begin
            @(negedge i_clk);
            w++;
        end
        if (!o_valid) timeout("bp_valid_wait");
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            check("bp_result", o_result, req);
            check("bp_valid", 32'(o_valid), 32'd1);
            check("bp_ready", 32'(o_ready), 32'd0);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        check("post_hs_ready", 32'(o_ready), 32'd1);
        issue(OP_MULHU, 32'd65536, 32'd65536, 32'h0000_0001); wait_idle();

        // Reset in the middle of CALC discards the operation.
        issue(OP_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D, model(OP_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D));
        repeat (17) @(negedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(o_valid), 32'd0);
        check("mid_rst_ready", 32'(o_ready), 32'd1);
        check("mid_rst_result", o_result, 32'h0);
        sb_q.delete();
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        issue(OP_MUL, 32'd3, 32'd4, 32'h0000_000C); wait_idle();

        // Randomized operations, biased toward sign-boundary operands.
        for (int i = 0; i < 40; i++) begin
            op = mul_op_t'(2'($urandom_range(0, 3)));
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
            issue(op, a, b, model(op, a, b));
            wait_idle();
        end

        repeat (3) @(negedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
